// File: rtl/main_ctrl_fsm_pkg.sv
// Shared types and constants for the multi-cycle main control unit:
// FSM state encoding, ALU operation codes and the opcodes it decodes.
package main_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecR,
        StExecAddr,
        StExecBr,
        StMem,
        StWb,
        StTrap
    } state_e;

    typedef enum logic [1:0] {
        AluopAdd   = 2'b00,
        AluopSub   = 2'b01,
        AluopFunct = 2'b10
    } aluop_e;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [2:0] Funct3Beq = 3'b000;

    // Anything that is not R-type, load/store or beq is illegal.
    function automatic state_e decode_next(logic [6:0] opcode, logic [2:0] funct3);
        state_e nxt;
        nxt = StTrap;
        case (opcode)
            OpcR:              nxt = StExecR;
            OpcLoad, OpcStore: nxt = StExecAddr;
            OpcBranch:         nxt = (funct3 == Funct3Beq) ? StExecBr : StTrap;
            default:           nxt = StTrap;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/main_ctrl_fsm_if.sv
// Memory handshake and alu_ctrl signals between the main control unit (master)
// and the memory / ALU-control side (slave).
interface main_ctrl_fsm_if;

    logic       mem_req;
    logic       mem_we;
    logic       mem_sel_data;
    logic       mem_ready;
    logic [1:0] aluop;
    logic [3:0] inst_alu;

    modport master (
        output mem_req,
        output mem_we,
        output mem_sel_data,
        output aluop,
        output inst_alu,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_sel_data,
        input  aluop,
        input  inst_alu,
        output mem_ready
    );

endinterface

// File: rtl/main_ctrl_fsm_mem_wait_timer.sv
// Memory-wait timeout: down-counter reloaded with WAIT_MAX on clear; expired_o flags
// the enabled cycle that would make the WAIT_MAX-th consecutive wait.
module main_ctrl_fsm_mem_wait_timer #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned Width = $clog2(WAIT_MAX + 1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = Width'(WAIT_MAX);
        end else if (en_i) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= Width'(WAIT_MAX);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == Width'(1));

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle main control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath enables and alu_ctrl, times out stalled memory and counts retired instructions.
module main_ctrl_fsm
    import main_ctrl_fsm_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [31:0]         instr_i,
    input  logic                zero_i,
    main_ctrl_fsm_if.master     bus_io,
    output logic                ir_write_o,
    output logic                pc_write_o,
    output logic                pc_src_o,
    output logic                reg_write_o,
    output logic                alu_src_o,
    output logic                mem_to_reg_o,
    output logic                busy_o,
    output logic                trap_o,
    output logic [31:0]         instret_o
);

    state_e      state_q, state_d;
    logic [31:0] instret_q, instret_d;

    logic        mem_req;
    logic        mem_we;
    logic        mem_sel_data;
    aluop_e      aluop;
    logic [3:0]  inst_alu;
    logic        in_mem_phase;
    logic        wait_expired;
    logic        is_load;
    logic        is_store;
    logic [3:0]  funct_bits;

    assign is_load    = (instr_i[6:0] == OpcLoad);
    assign is_store   = (instr_i[6:0] == OpcStore);
    assign funct_bits = {instr_i[30], instr_i[14:12]};

    // Holding the counter cleared outside FETCH/MEM gives a fresh count on every entry.
    assign in_mem_phase = (state_q == StFetch) || (state_q == StMem);

    main_ctrl_fsm_mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!in_mem_phase || bus_io.mem_ready),
        .en_i      (mem_req && !bus_io.mem_ready),
        .expired_o (wait_expired)
    );

    always_comb begin
        state_d      = state_q;
        instret_d    = instret_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        aluop        = AluopAdd;
        inst_alu     = 4'b0000;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        pc_src_o     = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        trap_o       = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                mem_req = 1'b1;
                if (bus_io.mem_ready) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = StDecode;
                end else if (wait_expired) begin
                    state_d = StTrap;
                end
            end
            StDecode: begin
                state_d = decode_next(instr_i[6:0], instr_i[14:12]);
            end
            StExecR: begin
                aluop    = AluopFunct;
                inst_alu = funct_bits;
                state_d  = StWb;
            end
            StExecAddr: begin
                alu_src_o = 1'b1;
                state_d   = StMem;
            end
            StExecBr: begin
                aluop = AluopSub;
                if (zero_i) begin
                    pc_write_o = 1'b1;
                    pc_src_o   = 1'b1;
                end
                instret_d = instret_q + 32'd1;
                state_d   = StFetch;
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                alu_src_o    = 1'b1;
                mem_we       = is_store;
                if (bus_io.mem_ready) begin
                    if (is_store) begin
                        instret_d = instret_q + 32'd1;
                        state_d   = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_expired) begin
                    state_d = StTrap;
                end
            end
            StWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = is_load;
                aluop        = is_load ? AluopAdd : AluopFunct;
                inst_alu     = funct_bits;
                instret_d    = instret_q + 32'd1;
                state_d      = StFetch;
            end
            StTrap: begin
                trap_o = 1'b1;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign bus_io.mem_req      = mem_req;
    assign bus_io.mem_we       = mem_we;
    assign bus_io.mem_sel_data = mem_sel_data;
    assign bus_io.aluop        = aluop;
    assign bus_io.inst_alu     = inst_alu;

    assign busy_o    = (state_q != StIdle) && (state_q != StTrap);
    assign instret_o = instret_q;

    logic unused_instr;
    assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed, table-driven bench for main_ctrl_fsm: one row per clock cycle with the
// expected packed control outputs and retired count, plus hand-written reset/timeout runs.
module tb_main_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic        zero;
    logic        ir_write, pc_write, pc_src, reg_write, alu_src, mem_to_reg;
    logic        busy, trap;
    logic [31:0] instret;

    main_ctrl_fsm_if bus ();

    main_ctrl_fsm #(
        .WAIT_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .instr_i      (instr),
        .zero_i       (zero),
        .bus_io       (bus),
        .ir_write_o   (ir_write),
        .pc_write_o   (pc_write),
        .pc_src_o     (pc_src),
        .reg_write_o  (reg_write),
        .alu_src_o    (alu_src),
        .mem_to_reg_o (mem_to_reg),
        .busy_o       (busy),
        .trap_o       (trap),
        .instret_o    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, mem_we, mem_sel_data, ir_write, pc_write, pc_src, reg_write,
    //  alu_src, mem_to_reg, aluop[1:0], inst_alu[3:0], busy, trap}
    logic [16:0] ctl;
    assign ctl = {bus.mem_req, bus.mem_we, bus.mem_sel_data, ir_write, pc_write, pc_src,
                  reg_write, alu_src, mem_to_reg, bus.aluop, bus.inst_alu, busy, trap};

    localparam logic [16:0] CIdle   = 17'h00000;
    localparam logic [16:0] CFetchW = 17'h10002;
    localparam logic [16:0] CFetchR = 17'h13002;
    localparam logic [16:0] CDec    = 17'h00002;
    localparam logic [16:0] CExR    = 17'h00082;
    localparam logic [16:0] CWbR    = 17'h00482;
    localparam logic [16:0] CExA    = 17'h00202;
    localparam logic [16:0] CMemL   = 17'h14202;
    localparam logic [16:0] CMemS   = 17'h1C202;
    localparam logic [16:0] CWbLw   = 17'h0050A;
    localparam logic [16:0] CBrT    = 17'h01842;
    localparam logic [16:0] CBrN    = 17'h00042;
    localparam logic [16:0] CTrap   = 17'h00001;

    localparam logic [31:0] IAdd = 32'h002081B3;
    localparam logic [31:0] ILw  = 32'h0000A103;
    localparam logic [31:0] ISw  = 32'h0020A023;
    localparam logic [31:0] IBeq = 32'h00000463;
    localparam logic [31:0] IBne = 32'h00001463;
    localparam logic [31:0] IIll = 32'h0000007F;

    typedef struct {
        logic        rst;
        logic        start;
        logic        rdy;
        logic        zero;
        logic [31:0] instr;
        logic [16:0] exp_ctl;
        logic [31:0] exp_ret;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t v(logic r, logic s, logic m, logic z, logic [31:0] i,
                               logic [16:0] c, logic [31:0] n);
        vec_t t;
        t.rst = r; t.start = s; t.rdy = m; t.zero = z; t.instr = i;
        t.exp_ctl = c; t.exp_ret = n;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        rst = t.rst; start = t.start; bus.mem_ready = t.rdy; zero = t.zero; instr = t.instr;
        #1;
        check({tag, " ctl"}, {15'd0, ctl}, {15'd0, t.exp_ctl});
        check({tag, " instret"}, instret, t.exp_ret);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; zero = 1'b0; instr = 32'd0; bus.mem_ready = 1'b0;

        // R-type add, 1-cycle memory; start while busy is ignored
        vecs.push_back(v(1, 0, 0, 0, IAdd, CIdle,   0));
        vecs.push_back(v(0, 1, 0, 0, IAdd, CIdle,   0));
        vecs.push_back(v(0, 0, 1, 0, IAdd, CFetchR, 0));
        vecs.push_back(v(0, 1, 0, 0, IAdd, CDec,    0));
        vecs.push_back(v(0, 0, 1, 0, IAdd, CExR,    0));
        vecs.push_back(v(0, 0, 0, 0, IAdd, CWbR,    0));
        vecs.push_back(v(0, 0, 0, 0, IAdd, CFetchW, 1));
        // lw with mem_ready delayed 3 cycles in MEM
        vecs.push_back(v(1, 0, 0, 0, ILw,  CIdle,   0));
        vecs.push_back(v(0, 1, 0, 0, ILw,  CIdle,   0));
        vecs.push_back(v(0, 0, 1, 0, ILw,  CFetchR, 0));
        vecs.push_back(v(0, 0, 0, 0, ILw,  CDec,    0));
        vecs.push_back(v(0, 0, 0, 0, ILw,  CExA,    0));
        vecs.push_back(v(0, 0, 0, 0, ILw,  CMemL,   0));
        vecs.push_back(v(0, 0, 0, 0, ILw,  CMemL,   0));
        vecs.push_back(v(0, 0, 0, 0, ILw,  CMemL,   0));
        vecs.push_back(v(0, 0, 1, 0, ILw,  CMemL,   0));
        vecs.push_back(v(0, 0, 0, 0, ILw,  CWbLw,   0));
        vecs.push_back(v(0, 0, 0, 0, ILw,  CFetchW, 1));
        // sw, beq taken, beq not taken
        vecs.push_back(v(1, 0, 0, 0, ISw,  CIdle,   0));
        vecs.push_back(v(0, 1, 0, 0, ISw,  CIdle,   0));
        vecs.push_back(v(0, 0, 1, 0, ISw,  CFetchR, 0));
        vecs.push_back(v(0, 0, 0, 0, ISw,  CDec,    0));
        vecs.push_back(v(0, 0, 0, 0, ISw,  CExA,    0));
        vecs.push_back(v(0, 0, 1, 0, ISw,  CMemS,   0));
        vecs.push_back(v(0, 0, 1, 1, IBeq, CFetchR, 1));
        vecs.push_back(v(0, 0, 0, 1, IBeq, CDec,    1));
        vecs.push_back(v(0, 0, 0, 1, IBeq, CBrT,    1));
        vecs.push_back(v(0, 0, 1, 0, IBeq, CFetchR, 2));
        vecs.push_back(v(0, 0, 0, 0, IBeq, CDec,    2));
        vecs.push_back(v(0, 0, 0, 0, IBeq, CBrN,    2));
        vecs.push_back(v(0, 0, 0, 1, IBeq, CFetchW, 3));
        // illegal opcode 0x7F: sticky trap, start and mem_ready ignored
        vecs.push_back(v(1, 0, 0, 0, IIll, CIdle,   0));
        vecs.push_back(v(0, 1, 0, 0, IIll, CIdle,   0));
        vecs.push_back(v(0, 0, 1, 0, IIll, CFetchR, 0));
        vecs.push_back(v(0, 0, 0, 0, IIll, CDec,    0));
        vecs.push_back(v(0, 0, 0, 0, IIll, CTrap,   0));
        vecs.push_back(v(0, 1, 1, 1, IIll, CTrap,   0));
        vecs.push_back(v(0, 0, 0, 0, IIll, CTrap,   0));
        // branch opcode with funct3 != 000 is illegal
        vecs.push_back(v(1, 0, 0, 0, IBne, CIdle,   0));
        vecs.push_back(v(0, 1, 0, 0, IBne, CIdle,   0));
        vecs.push_back(v(0, 0, 1, 0, IBne, CFetchR, 0));
        vecs.push_back(v(0, 0, 0, 0, IBne, CDec,    0));
        vecs.push_back(v(0, 0, 0, 0, IBne, CTrap,   0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Async reset in the middle of a MEM wait after one retired store
        apply(v(1, 0, 0, 0, ISw, CIdle,   0), "rstmem pre");
        apply(v(0, 1, 0, 0, ISw, CIdle,   0), "rstmem start");
        apply(v(0, 0, 1, 0, ISw, CFetchR, 0), "rstmem fetch sw");
        apply(v(0, 0, 0, 0, ISw, CDec,    0), "rstmem dec sw");
        apply(v(0, 0, 0, 0, ISw, CExA,    0), "rstmem exa sw");
        apply(v(0, 0, 1, 0, ISw, CMemS,   0), "rstmem mem sw");
        apply(v(0, 0, 1, 0, ILw, CFetchR, 1), "rstmem fetch lw");
        apply(v(0, 0, 0, 0, ILw, CDec,    1), "rstmem dec lw");
        apply(v(0, 0, 0, 0, ILw, CExA,    1), "rstmem exa lw");
        apply(v(0, 0, 0, 0, ILw, CMemL,   1), "rstmem mem wait");
        #1 rst = 1'b1;
        #1;
        check("rstmem async ctl", {15'd0, ctl}, 32'd0);
        check("rstmem async busy", {31'd0, busy}, 32'd0);
        check("rstmem async instret", instret, 32'd0);
        apply(v(0, 0, 0, 0, ILw, CIdle,   0), "rstmem released");
        apply(v(0, 0, 0, 0, ILw, CIdle,   0), "rstmem idle");

        // FETCH timeout: four waiting cycles then TRAP
        apply(v(1, 0, 0, 0, IAdd, CIdle, 0), "tofetch rst");
        apply(v(0, 1, 0, 0, IAdd, CIdle, 0), "tofetch start");
        for (int k = 0; k < 4; k++) apply(v(0, 0, 0, 0, IAdd, CFetchW, 0), "tofetch wait");
        apply(v(0, 0, 1, 0, IAdd, CTrap, 0), "tofetch trap");

        // mem_ready on the fourth waiting cycle wins over the timeout
        apply(v(1, 0, 0, 0, IAdd, CIdle, 0), "rdywin rst");
        apply(v(0, 1, 0, 0, IAdd, CIdle, 0), "rdywin start");
        for (int k = 0; k < 3; k++) apply(v(0, 0, 0, 0, IAdd, CFetchW, 0), "rdywin wait");
        apply(v(0, 0, 1, 0, IAdd, CFetchR, 0), "rdywin ready");
        apply(v(0, 0, 0, 0, IAdd, CDec,    0), "rdywin decode");

        // MEM timeout on a store
        apply(v(1, 0, 0, 0, ISw, CIdle,   0), "tomem rst");
        apply(v(0, 1, 0, 0, ISw, CIdle,   0), "tomem start");
        apply(v(0, 0, 1, 0, ISw, CFetchR, 0), "tomem fetch");
        apply(v(0, 0, 0, 0, ISw, CDec,    0), "tomem dec");
        apply(v(0, 0, 0, 0, ISw, CExA,    0), "tomem exa");
        for (int k = 0; k < 4; k++) apply(v(0, 0, 0, 0, ISw, CMemS, 0), "tomem wait");
        apply(v(0, 0, 0, 0, ISw, CTrap,   0), "tomem trap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
